// File: rtl/somador_pkg.sv
// Shared definitions for the bit-serial adder.
// State encodings and the default operand width.
package somador_pkg;

  localparam int SOMADOR_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/somador_completo.sv
// Single-bit full adder cell from the arithmetic library.
// Purely combinational.
module somador_completo (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Soma,
  output logic Cout
);

  assign Soma = A ^ B ^ Cin;
  assign Cout = (A & B) | (A & Cin) | (B & Cin);

endmodule

// File: rtl/somador_serial_32_bits.sv
// Bit-serial A + B + Cin, one bit per clock, start/done handshake.
// Results stay registered between operations.
module somador_serial_32_bits
  import somador_pkg::*;
#(
  parameter int WIDTH = SOMADOR_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Soma,
  output logic             Cout,
  output logic             Signal,
  output logic             Overflow
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0] r_ra;
  logic [WIDTH-1:0] r_rb;
  logic [WIDTH-1:0] r_acc;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_sa;
  logic             r_sb;
  logic [WIDTH-1:0] r_soma;
  logic             r_cout;
  logic             r_ovf;

  logic w_s;
  logic w_c;
  logic w_accept;
  logic w_last;

  somador_completo u_fa (
    .A    (r_ra[0]),
    .B    (r_rb[0]),
    .Cin  (r_carry),
    .Soma (w_s),
    .Cout (w_c)
  );

  assign w_accept = start &&
                    (r_state == ST_IDLE || r_state == ST_DONE);
  assign w_last   = (r_state == ST_ADD) &&
                    (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: if (start) w_next = ST_ADD;
      ST_ADD:  if (w_last) w_next = ST_DONE;
      ST_DONE: w_next = start ? ST_ADD : ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ra    <= '0;
      r_rb    <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_sa    <= 1'b0;
      r_sb    <= 1'b0;
      r_soma  <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_ra    <= A;
      r_rb    <= B;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_carry <= Cin;
      r_sa    <= A[WIDTH-1];
      r_sb    <= B[WIDTH-1];
    end else if (r_state == ST_ADD) begin
      r_ra    <= r_ra >> 1;
      r_rb    <= r_rb >> 1;
      r_acc   <= {w_s, r_acc[WIDTH-1:1]};
      r_carry <= w_c;
      r_cnt   <= r_cnt + 1'b1;
      // Publish only on the final step; w_s is the new MSB here
      if (w_last) begin
        r_soma <= {w_s, r_acc[WIDTH-1:1]};
        r_cout <= w_c;
        r_ovf  <= (r_sa == r_sb) && (w_s != r_sa);
      end
    end
  end

  assign busy     = (r_state == ST_ADD);
  assign done     = (r_state == ST_DONE);
  assign Soma     = r_soma;
  assign Cout     = r_cout;
  assign Signal   = r_soma[WIDTH-1];
  assign Overflow = r_ovf;

endmodule

// File: tb/tb_somador_serial_32_bits.sv
// Directed bench for the bit-serial adder.
// Hand-computed sums, handshake timing and control cases.
module tb_somador_serial_32_bits;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic        Cin;
  logic        busy;
  logic        done;
  logic [31:0] Soma;
  logic        Cout;
  logic        Signal;
  logic        Overflow;

  int n_chk;
  int n_fail;

  somador_serial_32_bits dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .A        (A),
    .B        (B),
    .Cin      (Cin),
    .busy     (busy),
    .done     (done),
    .Soma     (Soma),
    .Cout     (Cout),
    .Signal   (Signal),
    .Overflow (Overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_op(input logic [31:0] a,
                       input logic [31:0] b,
                       input logic c,
                       output int nbusy,
                       output bit ok);
    @(negedge clk);
    A = a; B = b; Cin = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nbusy = 0;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      if (busy) nbusy++;
      @(negedge clk);
    end
  endtask

  task automatic check_res(input string tag,
                           input logic [31:0] s,
                           input logic co,
                           input logic sg,
                           input logic ov);
    check({tag, ".soma"}, 64'(Soma), 64'(s));
    check({tag, ".cout"}, 64'(Cout), 64'(co));
    check({tag, ".sig"}, 64'(Signal), 64'(sg));
    check({tag, ".ovf"}, 64'(Overflow), 64'(ov));
  endtask

  int nb;
  bit ok;
  bit bad;
  int cnt;

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst = 1'b1; start = 1'b0;
    A = '0; B = '0; Cin = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy || done || Soma != 0 || Cout || Signal || Overflow)
        bad = 1'b1;
    end
    check("rst_idle", 64'(bad), 64'd0);

    do_op(32'd5, 32'd3, 1'b0, nb, ok);
    check("add1.done", 64'(ok), 64'd1);
    check("add1.busy", 64'(nb), 64'd32);
    check_res("add1", 32'h8, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("add1.pulse", 64'(done), 64'd0);

    do_op(32'hFFFFFFFF, 32'h1, 1'b0, nb, ok);
    check("wrap.done", 64'(ok), 64'd1);
    check_res("wrap", 32'h0, 1'b1, 1'b0, 1'b0);

    do_op(32'h7FFFFFFF, 32'h1, 1'b0, nb, ok);
    check("ovf.done", 64'(ok), 64'd1);
    check_res("ovf", 32'h80000000, 1'b0, 1'b1, 1'b1);

    do_op(32'h12345678, 32'hFFFFFFEF, 1'b1, nb, ok);
    check("sub.done", 64'(ok), 64'd1);
    check_res("sub", 32'h12345668, 1'b1, 1'b0, 1'b0);

    // start pulse mid-operation must be ignored
    @(negedge clk);
    A = 32'h100; B = 32'h23; Cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    A = 32'hDEAD0000; B = 32'h0000BEEF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nb = 5;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      if (busy) nb++;
      @(negedge clk);
    end
    check("ign.done", 64'(ok), 64'd1);
    check("ign.busy", 64'(nb), 64'd32);
    check_res("ign", 32'h123, 1'b0, 1'b0, 1'b0);

    // reset in the middle of an operation
    @(negedge clk);
    A = 32'h100; B = 32'h200; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("mid.busy_pre", 64'(busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid.busy", 64'(busy), 64'd0);
    check("mid.done", 64'(done), 64'd0);
    check("mid.soma", 64'(Soma), 64'd0);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) cnt++;
    end
    check("mid.nodone", 64'(cnt), 64'd0);

    do_op(32'd5, 32'd3, 1'b0, nb, ok);
    check("fresh.done", 64'(ok), 64'd1);
    check("fresh.busy", 64'(nb), 64'd32);
    check_res("fresh", 32'h8, 1'b0, 1'b0, 1'b0);

    // start held through done: back-to-back accept
    @(negedge clk);
    A = 32'd5; B = 32'd3; Cin = 1'b0; start = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    check("b2b.done1", 64'(ok), 64'd1);
    check("b2b.soma1", 64'(Soma), 64'd8);
    A = 32'd1; B = 32'd2;
    cnt = 0;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      start = 1'b0;
      cnt++;
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    check("b2b.done2", 64'(ok), 64'd1);
    check("b2b.lat", 64'(cnt), 64'd33);
    check("b2b.soma2", 64'(Soma), 64'd3);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
